protocol_frame_fsm: RTL and testbench

Parametrised Mealy-style frame receiver, successor to the 2-bit handshake protocol FSM. It accepts a stream of W-bit symbols framed as START, LEN, LEN payload symbols, CHK. Payload passes through combinationally in the cycle it is accepted, and the block flags frame success or failure (bad length, bad checksum, timeout, abort). It sits between the symbol input pins and the downstream payload consumer, and keeps a saturating count of good frames.

---
 rtl/protocol_frame_fsm.sv | 164 ++++++++++++++++
 tb/tb_protocol_frame_fsm.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/protocol_frame_fsm.sv
// rtl/protocol_frame_fsm.sv - Mealy frame receiver: START, LEN, payload, CHK with error flags and good-frame count
module protocol_frame_fsm #(
  parameter int W         = 4,
  parameter int MAX_LEN   = 8,
  parameter int TIMEOUT   = 16,
  parameter int START_SYM = 1,
  parameter int CNT_W     = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [W-1:0]     e,
  input  logic             e_valid,
  input  logic             abort,
  output logic [W-1:0]     y,
  output logic             y_valid,
  output logic             frame_ok,
  output logic             frame_err,
  output logic [1:0]       err_code,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] frame_cnt
);

  localparam int            IW       = $clog2(TIMEOUT + 1);
  localparam logic [W-1:0]  START_V  = W'(START_SYM);
  localparam logic [W-1:0]  MAX_V    = W'(MAX_LEN);
  localparam logic [W-1:0]  ONE_V    = W'(1);
  localparam logic [IW-1:0] IDLE_LIM = IW'(TIMEOUT - 1);

  localparam logic [1:0] ERR_ABORT   = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_CHK     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LEN  = 2'd1,
    S_DATA = 2'd2,
    S_CHK  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [W-1:0]    rem_q, rem_d;
  logic [W-1:0]    acc_q, acc_d;
  logic [IW-1:0]   idle_q, idle_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic accept;
  logic len_ok;
  logic in_frame;
  logic timed_out;

  assign accept    = e_valid && !abort;
  assign len_ok    = (e != '0) && (e <= MAX_V);
  assign in_frame  = (state_q != S_IDLE);
  assign timed_out = in_frame && !e_valid && (idle_q == IDLE_LIM);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      acc_q   <= '0;
      idle_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      acc_q   <= acc_d;
      idle_q  <= idle_d;
      cnt_q   <= cnt_d;
    end
  end

  // Abort beats an accepted symbol, which beats the idle timeout.
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    acc_d   = acc_q;
    idle_d  = idle_q;
    cnt_d   = cnt_q;
    if (in_frame && abort) begin
      state_d = S_IDLE;
      idle_d  = '0;
    end else if (accept) begin
      idle_d = '0;
      case (state_q)
        S_IDLE: begin
          if (e == START_V) begin
            state_d = S_LEN;
            acc_d   = '0;
          end
        end
        S_LEN: begin
          if (len_ok) begin
            rem_d   = e;
            acc_d   = e;
            state_d = S_DATA;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_DATA: begin
          acc_d = acc_q ^ e;
          rem_d = rem_q - ONE_V;
          if (rem_q == ONE_V) begin
            state_d = S_CHK;
          end
        end
        S_CHK: begin
          state_d = S_IDLE;
          if ((e == acc_q) && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end else if (timed_out) begin
      state_d = S_IDLE;
      idle_d  = '0;
    end else if (in_frame && !e_valid) begin
      idle_d = idle_q + 1'b1;
    end
  end

  always_comb begin
    y         = '0;
    y_valid   = 1'b0;
    frame_ok  = 1'b0;
    frame_err = 1'b0;
    err_code  = 2'd0;
    if (in_frame && abort) begin
      frame_err = 1'b1;
      err_code  = ERR_ABORT;
    end else if (accept) begin
      case (state_q)
        S_LEN: begin
          if (!len_ok) begin
            frame_err = 1'b1;
            err_code  = ERR_LEN;
          end
        end
        S_DATA: begin
          y       = e;
          y_valid = 1'b1;
        end
        S_CHK: begin
          if (e == acc_q) begin
            frame_ok = 1'b1;
          end else begin
            frame_err = 1'b1;
            err_code  = ERR_CHK;
          end
        end
        default: ;
      endcase
    end else if (timed_out) begin
      frame_err = 1'b1;
      err_code  = ERR_TIMEOUT;
    end
  end

  assign state     = state_q;
  assign frame_cnt = cnt_q;

endmodule

// File: tb/tb_protocol_frame_fsm.sv
// tb/tb_protocol_frame_fsm.sv - scoreboard bench for protocol_frame_fsm (W=4, MAX_LEN=8, TIMEOUT=16, CNT_W=2)
module tb_protocol_frame_fsm;

  logic       clk;
  logic       reset_n;
  logic [3:0] e;
  logic       e_valid;
  logic       abort;
  logic [3:0] y;
  logic       y_valid;
  logic       frame_ok;
  logic       frame_err;
  logic [1:0] err_code;
  logic [1:0] state;
  logic [1:0] frame_cnt;

  int checks = 0;
  int errors = 0;
  logic [1:0] exp_cnt;

  typedef struct {
    logic [3:0] y;
    logic       yv;
    logic       ok;
    logic       err;
    logic [1:0] code;
    logic [1:0] st;
  } exp_t;

  exp_t sb[$];

  protocol_frame_fsm #(
    .W(4), .MAX_LEN(8), .TIMEOUT(16), .START_SYM(1), .CNT_W(2)
  ) dut (
    .clk(clk), .reset_n(reset_n), .e(e), .e_valid(e_valid), .abort(abort),
    .y(y), .y_valid(y_valid), .frame_ok(frame_ok), .frame_err(frame_err),
    .err_code(err_code), .state(state), .frame_cnt(frame_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      checks += 6;
      if (y !== x.y) begin
        errors++; $display("FAIL y: got %h want %h at %0t", y, x.y, $time);
      end
      if (y_valid !== x.yv) begin
        errors++; $display("FAIL y_valid: got %b want %b at %0t", y_valid, x.yv, $time);
      end
      if (frame_ok !== x.ok) begin
        errors++; $display("FAIL frame_ok: got %b want %b at %0t", frame_ok, x.ok, $time);
      end
      if (frame_err !== x.err) begin
        errors++; $display("FAIL frame_err: got %b want %b at %0t", frame_err, x.err, $time);
      end
      if (err_code !== x.code) begin
        errors++; $display("FAIL err_code: got %0d want %0d at %0t", err_code, x.code, $time);
      end
      if (state !== x.st) begin
        errors++; $display("FAIL state: got %0d want %0d at %0t", state, x.st, $time);
      end
    end
  end

  // One clock cycle: expectations pushed with the stimulus, compared at the falling edge.
  task automatic cyc(input logic [3:0] sym, input logic v, input logic ab,
                     input logic yv, input logic ok, input logic er,
                     input logic [1:0] code, input logic [1:0] st);
    exp_t x;
    x.y = yv ? sym : 4'h0;
    x.yv = yv; x.ok = ok; x.err = er; x.code = code; x.st = st;
    sb.push_back(x);
    e = sym; e_valid = v; abort = ab;
    @(posedge clk); #1;
    e_valid = 1'b0; abort = 1'b0; e = 4'h0;
  endtask

  task automatic check_state_cnt(input string tag, input logic [1:0] st);
    checks += 2;
    if (state !== st) begin
      errors++; $display("FAIL %s state: got %0d want %0d", tag, state, st);
    end
    if (frame_cnt !== exp_cnt) begin
      errors++; $display("FAIL %s frame_cnt: got %0d want %0d", tag, frame_cnt, exp_cnt);
    end
  endtask

  task automatic good_frame(input logic [3:0] d);
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(d,    1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'h1 ^ d, 1, 0, 0, 1, 0, 2'd0, 2'd3);
    if (exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0; e = 4'h1; e_valid = 1'b1; abort = 1'b0;
    #12;
    checks += 5;
    if (y !== 4'h0 || y_valid !== 1'b0) begin
      errors++; $display("FAIL reset_payload: got y=%h v=%b want 0 0", y, y_valid);
    end
    if (frame_ok !== 1'b0 || frame_err !== 1'b0) begin
      errors++; $display("FAIL reset_flags: got ok=%b err=%b want 0 0", frame_ok, frame_err);
    end
    if (err_code !== 2'd0) begin
      errors++; $display("FAIL reset_code: got %0d want 0", err_code);
    end
    if (state !== 2'd0) begin
      errors++; $display("FAIL reset_state: got %0d want 0", state);
    end
    if (frame_cnt !== 2'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", frame_cnt);
    end
    e_valid = 1'b0; e = 4'h0;
    reset_n = 1'b1;
    exp_cnt = 2'd0;
    @(posedge clk); #1;
  endtask

  task automatic test_good_frame;
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h3, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'hA, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'h5, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'hC, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'h0, 1, 0, 0, 1, 0, 2'd0, 2'd3);
    exp_cnt = 2'd1;
    check_state_cnt("good_frame", 2'd0);
    cyc(4'h7, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    check_state_cnt("idle_ignore", 2'd0);
  endtask

  task automatic test_bad_len;
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h0, 1, 0, 0, 0, 1, 2'd1, 2'd1);
    check_state_cnt("len_zero", 2'd0);
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h9, 1, 0, 0, 0, 1, 2'd1, 2'd1);
    check_state_cnt("len_nine", 2'd0);
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h8, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'h1, 1, 1, 0, 0, 1, 2'd0, 2'd2);
  endtask

  task automatic test_bad_chk;
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h2, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'h4, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'h4, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'hF, 1, 0, 0, 0, 1, 2'd2, 2'd3);
    check_state_cnt("bad_chk", 2'd0);
  endtask

  task automatic test_timeout;
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h2, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'h6, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    for (int i = 0; i < 15; i++) cyc(4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd2);
    cyc(4'h0, 0, 0, 0, 0, 1, 2'd3, 2'd2);
    check_state_cnt("timeout", 2'd0);
    // Same frame, but a symbol lands in the threshold cycle.
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h2, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'h6, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    for (int i = 0; i < 15; i++) cyc(4'h0, 0, 0, 0, 0, 0, 2'd0, 2'd2);
    cyc(4'h7, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'h3, 1, 0, 0, 1, 0, 2'd0, 2'd3);
    exp_cnt = 2'd2;
    check_state_cnt("timeout_rescue", 2'd0);
  endtask

  task automatic test_abort;
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h3, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'hA, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    cyc(4'h5, 1, 1, 0, 0, 1, 2'd0, 2'd2);
    check_state_cnt("abort_data", 2'd0);
    cyc(4'h1, 1, 1, 0, 0, 0, 2'd0, 2'd0);
    check_state_cnt("abort_idle", 2'd0);
  endtask

  task automatic test_reset_mid;
    cyc(4'h1, 1, 0, 0, 0, 0, 2'd0, 2'd0);
    cyc(4'h3, 1, 0, 0, 0, 0, 2'd0, 2'd1);
    cyc(4'hA, 1, 0, 1, 0, 0, 2'd0, 2'd2);
    e = 4'h5; e_valid = 1'b1;
    #1;
    checks++;
    if (y_valid !== 1'b1) begin
      errors++; $display("FAIL pre_reset_y_valid: got %b want 1", y_valid);
    end
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (y !== 4'h0 || y_valid !== 1'b0 || frame_ok !== 1'b0) begin
      errors++; $display("FAIL midreset_out: got y=%h v=%b ok=%b want 0 0 0", y, y_valid, frame_ok);
    end
    if (frame_err !== 1'b0 || err_code !== 2'd0) begin
      errors++; $display("FAIL midreset_err: got err=%b code=%0d want 0 0", frame_err, err_code);
    end
    if (state !== 2'd0 || frame_cnt !== 2'd0) begin
      errors++; $display("FAIL midreset_regs: got st=%0d cnt=%0d want 0 0", state, frame_cnt);
    end
    e_valid = 1'b0; e = 4'h0;
    #1;
    reset_n = 1'b1;
    exp_cnt = 2'd0;
    @(posedge clk); #1;
    good_frame(4'h7);
    check_state_cnt("after_reset", 2'd0);
  endtask

  task automatic test_back_to_back;
    logic [1:0] want[5];
    want = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    exp_cnt = 2'd0;
    @(posedge clk); #1;
    for (int i = 0; i < 5; i++) begin
      good_frame(4'(i + 2));
      checks++;
      if (frame_cnt !== want[i]) begin
        errors++; $display("FAIL saturate[%0d]: got %0d want %0d", i, frame_cnt, want[i]);
      end
    end
  endtask

  initial begin
    e = 4'h0; e_valid = 1'b0; abort = 1'b0; reset_n = 1'b0; exp_cnt = 2'd0;
    test_reset;
    test_good_frame;
    test_bad_len;
    test_bad_chk;
    test_timeout;
    test_abort;
    test_reset_mid;
    test_back_to_back;
    @(posedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
